// File: rtl/beam_pkg.sv
// Shared constants for the beam sum / integrate block.
//   NCH     number of CFIR slave channels summed (power of 2)
//   DW      per-channel and output sample width
//   MAXLOG  largest integration exponent k (block length 2^k)
//   SW      full-precision width of the channel sum
//   AW      integrator width, holds 2^MAXLOG full-precision sums
//   SAT_MAX / SAT_MIN  output clipping limits
package beam_pkg;

    localparam int NCH     = 4;
    localparam int DW      = 16;
    localparam int MAXLOG  = 8;
    localparam int LOG2NCH = $clog2(NCH);
    localparam int SW      = DW + LOG2NCH;
    localparam int AW      = SW + MAXLOG;
    localparam int KW      = 4;
    localparam int CW      = MAXLOG;

    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Exponents above MAXLOG are treated as MAXLOG.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        return (k > KW'(MAXLOG)) ? KW'(MAXLOG) : k;
    endfunction

    // Index of the last sample in a block of 2^k samples.
    function automatic logic [CW-1:0] last_idx(input logic [KW-1:0] k);
        logic [CW:0] len;
        len = (CW+1)'(1) << k;
        return CW'(len - 1'b1);
    endfunction

endpackage

// File: rtl/sat_round.sv
// Round-half-up arithmetic right shift of one integrator value, then clip to DW bits.
//   val_i    AW-bit signed value (accumulator plus current sum)
//   shift_i  shift amount k (0 = no rounding)
//   res_o    rounded, saturated DW-bit result
//   clip_o   high when res_o was clipped to SAT_MAX or SAT_MIN
module sat_round
    import beam_pkg::*;
(
    input  logic signed [AW-1:0] val_i,
    input  logic        [KW-1:0] shift_i,
    output logic signed [DW-1:0] res_o,
    output logic                 clip_o
);

    localparam logic signed [AW:0] HI = (AW+1)'(SAT_MAX);
    localparam logic signed [AW:0] LO = (AW+1)'(SAT_MIN);

    // One extra bit so adding the rounding constant can never wrap.
    function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] v,
                                                       input logic        [KW-1:0] k);
        logic signed [AW:0] ext;
        logic signed [AW:0] half;
        ext  = {v[AW-1], v};
        half = '0;
        if (k != '0) begin
            half = (AW+1)'(1) << (k - 1'b1);
        end
        return (ext + half) >>> k;
    endfunction

    // Returns {clip, value}.
    function automatic logic [DW:0] saturate(input logic signed [AW:0] v);
        if (v > HI) begin
            return {1'b1, SAT_MAX};
        end else if (v < LO) begin
            return {1'b1, SAT_MIN};
        end
        return {1'b0, v[DW-1:0]};
    endfunction

    logic [DW:0] sat_w;

    always_comb begin
        sat_w = saturate(round_shift(val_i, shift_i));
    end

    assign clip_o = sat_w[DW];
    assign res_o  = sat_w[DW-1:0];

endmodule

// File: rtl/beam_sum_integrate.sv
// Beam combiner: masks and sums NCH complex channel samples, then passes the sum
// through (k=0) or integrates-and-dumps over 2^k valid samples, rounding and
// saturating the result to DW bits.
//   CLK, rst                clock, synchronous active-high reset
//   din_valid               channel samples valid this cycle
//   din_real / din_imag     packed channel samples, ch i at [i*DW +: DW]
//   ch_en                   per-channel enable, disabled channel contributes 0
//   acc_log2                integration exponent k, clamped to MAXLOG
//   acc_clr                 abort partial block and in-flight samples
//   dout_real / dout_imag   beam output, held between strobes
//   dout_valid              one-cycle output strobe
//   sat_flag                with dout_valid, either part clipped
//   ovf_sticky              any clip since reset
module beam_sum_integrate
    import beam_pkg::*;
(
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic [NCH*DW-1:0]    din_real,
    input  logic [NCH*DW-1:0]    din_imag,
    input  logic [NCH-1:0]       ch_en,
    input  logic [KW-1:0]        acc_log2,
    input  logic                 acc_clr,
    output logic signed [DW-1:0] dout_real,
    output logic signed [DW-1:0] dout_imag,
    output logic                 dout_valid,
    output logic                 sat_flag,
    output logic                 ovf_sticky
);

    // ---- S1: register masked channel samples ----
    logic signed [DW-1:0] re_p1_q [NCH];
    logic signed [DW-1:0] im_p1_q [NCH];
    logic                 vld_p1_q;

    always_ff @(posedge CLK) begin
        if (rst || acc_clr) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= din_valid;
        end
        for (int i = 0; i < NCH; i++) begin
            re_p1_q[i] <= ch_en[i] ? din_real[i*DW +: DW] : '0;
            im_p1_q[i] <= ch_en[i] ? din_imag[i*DW +: DW] : '0;
        end
    end

    // ---- S2: full-precision adder tree ----
    logic signed [SW-1:0] sum_re_d, sum_im_d;
    logic signed [SW-1:0] sum_re_p2_q, sum_im_p2_q;
    logic                 vld_p2_q;

    always_comb begin
        sum_re_d = '0;
        sum_im_d = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_re_d = sum_re_d + SW'(re_p1_q[i]);
            sum_im_d = sum_im_d + SW'(im_p1_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst || acc_clr) begin
            vld_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
        end
        sum_re_p2_q <= sum_re_d;
        sum_im_p2_q <= sum_im_d;
    end

    // ---- S3: integrate-and-dump, round/saturate, output register ----
    logic signed [AW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic signed [AW-1:0] tot_re, tot_im;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic        [KW-1:0] k_q, k_cur;
    logic                 dump;
    logic signed [DW-1:0] rnd_re, rnd_im;
    logic                 clip_re, clip_im;
    logic signed [DW-1:0] dout_re_q, dout_im_q;
    logic                 dout_vld_q, sat_q, ovf_q;

    // k=0 falls out naturally: last_idx(0)=0, so every sample dumps unshifted.
    always_comb begin
        k_cur    = (cnt_q == '0) ? clamp_k(acc_log2) : k_q;
        tot_re   = acc_re_q + AW'(sum_re_p2_q);
        tot_im   = acc_im_q + AW'(sum_im_p2_q);
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        dump     = 1'b0;
        if (vld_p2_q) begin
            if (cnt_q == last_idx(k_cur)) begin
                dump     = 1'b1;
                acc_re_d = '0;
                acc_im_d = '0;
                cnt_d    = '0;
            end else begin
                acc_re_d = tot_re;
                acc_im_d = tot_im;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    sat_round u_sat_re (
        .val_i   (tot_re),
        .shift_i (k_cur),
        .res_o   (rnd_re),
        .clip_o  (clip_re)
    );

    sat_round u_sat_im (
        .val_i   (tot_im),
        .shift_i (k_cur),
        .res_o   (rnd_im),
        .clip_o  (clip_im)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (acc_clr) begin
            // Abort drops the sample being dumped this cycle; output data holds.
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            cnt_q      <= '0;
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            cnt_q      <= cnt_d;
            if (vld_p2_q) begin
                k_q <= k_cur;
            end
            dout_vld_q <= dump;
            sat_q      <= dump && (clip_re || clip_im);
            if (dump) begin
                dout_re_q <= rnd_re;
                dout_im_q <= rnd_im;
                if (clip_re || clip_im) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign dout_real  = dout_re_q;
    assign dout_imag  = dout_im_q;
    assign dout_valid = dout_vld_q;
    assign sat_flag   = sat_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_beam_sum_integrate.sv
module tb_beam_sum_integrate;

    logic               CLK = 1'b0;
    logic               rst;
    logic               din_valid;
    logic [63:0]        din_real;
    logic [63:0]        din_imag;
    logic [3:0]         ch_en;
    logic [3:0]         acc_log2;
    logic               acc_clr;
    logic signed [15:0] dout_real;
    logic signed [15:0] dout_imag;
    logic               dout_valid;
    logic               sat_flag;
    logic               ovf_sticky;

    beam_sum_integrate dut (
        .CLK        (CLK),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .ch_en      (ch_en),
        .acc_log2   (acc_log2),
        .acc_clr    (acc_clr),
        .dout_real  (dout_real),
        .dout_imag  (dout_imag),
        .dout_valid (dout_valid),
        .sat_flag   (sat_flag),
        .ovf_sticky (ovf_sticky)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint re;
        longint im;
        int     k;
        int     due;
    } ev_t;

    ev_t    pend[$];
    longint m_acc_re, m_acc_im;
    int     m_cnt, m_k, cyc;
    bit     armed = 1'b0;
    bit     e_vld, e_sat, e_ovf;
    longint e_re, e_im;

    function automatic longint chsum(input logic [63:0] d, input logic [3:0] en);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) s += longint'($signed(d[i*16 +: 16]));
        end
        return s;
    endfunction

    function automatic longint rnd(input longint v, input int k);
        if (k == 0) return v;
        return (v + (longint'(1) <<< (k - 1))) >>> k;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic integrate(input ev_t ev);
        longint r, i;
        if (m_cnt == 0) m_k = (ev.k > 8) ? 8 : ev.k;
        m_acc_re += ev.re;
        m_acc_im += ev.im;
        m_cnt++;
        if (m_cnt == (1 << m_k)) begin
            r     = rnd(m_acc_re, m_k);
            i     = rnd(m_acc_im, m_k);
            e_vld = 1'b1;
            e_re  = sat16(r);
            e_im  = sat16(i);
            e_sat = (e_re != r) || (e_im != i);
            if (e_sat) e_ovf = 1'b1;
            m_acc_re = 0;
            m_acc_im = 0;
            m_cnt    = 0;
        end
    endtask

    always @(posedge CLK) begin
        ev_t ev;
        cyc++;
        if (rst) begin
            pend.delete();
            m_acc_re = 0; m_acc_im = 0; m_cnt = 0; m_k = 0;
            e_vld = 0; e_sat = 0; e_ovf = 0; e_re = 0; e_im = 0;
            armed = 1'b1;
        end else if (armed) begin
            e_vld = 0;
            e_sat = 0;
            if (acc_clr) begin
                pend.delete();
                m_acc_re = 0; m_acc_im = 0; m_cnt = 0;
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    ev = pend.pop_front();
                    integrate(ev);
                end
                if (din_valid) begin
                    ev.re  = chsum(din_real, ch_en);
                    ev.im  = chsum(din_imag, ch_en);
                    ev.k   = int'(acc_log2);
                    ev.due = cyc + 2;
                    pend.push_back(ev);
                end
            end
        end
        #1;
        if (armed) begin
            chk($sformatf("m_valid@%0d", cyc), dout_valid, e_vld);
            chk($sformatf("m_re@%0d", cyc), dout_real, e_re);
            chk($sformatf("m_im@%0d", cyc), dout_imag, e_im);
            chk($sformatf("m_sat@%0d", cyc), sat_flag, e_sat);
            chk($sformatf("m_ovf@%0d", cyc), ovf_sticky, e_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_din(input int r0, r1, r2, r3, i0, i1, i2, i3);
        din_real = {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
        din_imag = {16'(i3), 16'(i2), 16'(i1), 16'(i0)};
    endtask

    // Called right after the capture edge of the last sample of a block.
    task automatic wait_strobe(input string nm, input int exp_lat,
                               input int er, input int ei, input bit es);
        int n;
        n = 1;
        while (!dout_valid && n < 12) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_re"}, dout_real, er);
        chk({nm, "_im"}, dout_imag, ei);
        chk({nm, "_sat"}, sat_flag, es);
    endtask

    task automatic count_step(inout int nstb, input string nm, input int er, input int ei);
        step();
        if (dout_valid) begin
            nstb++;
            chk({nm, "_re"}, dout_real, er);
            chk({nm, "_im"}, dout_imag, ei);
        end
    endtask

    initial begin
        int nstb;
        int v[4];
        rst = 1'b1; din_valid = 1'b0; din_real = '0; din_imag = '0;
        ch_en = 4'hF; acc_log2 = 4'd0; acc_clr = 1'b0;
        step(); step();
        chk("rst_re", dout_real, 0);
        chk("rst_im", dout_imag, 0);
        chk("rst_vld", dout_valid, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_ovf", ovf_sticky, 0);
        rst = 1'b0;
        step();

        // pass-through, simple sum
        set_din(100, 100, 100, 100, -50, -50, -50, -50);
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t1", 3, 400, -200, 1'b0);
        chk("t1_ovf", ovf_sticky, 0);
        step();

        // saturation both ways
        set_din(32767, 32767, 32767, 32767, 0, 0, 0, 0);
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t2hi", 3, 32767, 0, 1'b1);
        chk("t2hi_ovf", ovf_sticky, 1);
        set_din(-32768, -32768, -32768, -32768, 0, 0, 0, 0);
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t2lo", 3, -32768, 0, 1'b1);
        step();
        chk("t2_satdrop", sat_flag, 0);
        chk("t2_ovfhold", ovf_sticky, 1);

        // k=2 with gaps: sums 1,2,3,5
        acc_log2 = 4'd2; step(); step();
        v = '{1, 2, 3, 5};
        for (int j = 0; j < 3; j++) begin
            set_din(v[j], 0, 0, 0, -v[j], 0, 0, 0);
            din_valid = 1'b1; step(); din_valid = 1'b0;
            step(); step();
        end
        set_din(v[3], 0, 0, 0, -v[3], 0, 0, 0);
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t3", 3, 3, -3, 1'b0);

        // k=3 continuous stream, constant sum -7 / 7
        acc_log2 = 4'd3; step(); step(); step();
        set_din(-7, 0, 0, 0, 7, 0, 0, 0);
        nstb = 0;
        din_valid = 1'b1;
        for (int j = 0; j < 24; j++) count_step(nstb, "t4", -7, 7);
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) count_step(nstb, "t4", -7, 7);
        chk("t4_count", nstb, 3);

        // abort mid-block together with the 4th sample
        acc_log2 = 4'd2; step(); step();
        set_din(10, 0, 0, 0, 0, 0, 0, 0);
        nstb = 0;
        din_valid = 1'b1;
        for (int j = 0; j < 3; j++) count_step(nstb, "t5a", 0, 0);
        acc_clr = 1'b1;
        count_step(nstb, "t5a", 0, 0);
        acc_clr = 1'b0; din_valid = 1'b0;
        for (int j = 0; j < 6; j++) count_step(nstb, "t5a", 0, 0);
        chk("t5_nostrobe", nstb, 0);
        chk("t5_hold_re", dout_real, -7);
        set_din(4, 0, 0, 0, -4, 0, 0, 0);
        din_valid = 1'b1;
        for (int j = 0; j < 4; j++) count_step(nstb, "t5b", 4, -4);
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) count_step(nstb, "t5b", 4, -4);
        chk("t5_count", nstb, 1);

        // channel mask, then all channels off
        acc_log2 = 4'd0; ch_en = 4'b0101; step(); step();
        set_din(10, 1000, 20, 1000, 1, 500, 2, 500);
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t6", 3, 30, 3, 1'b0);
        ch_en = 4'b0000;
        din_valid = 1'b1; step(); din_valid = 1'b0;
        wait_strobe("t6off", 3, 0, 0, 1'b0);
        ch_en = 4'hF;

        // reset mid-block, then clean restart
        acc_log2 = 4'd2; step(); step();
        set_din(8, 0, 0, 0, 0, 0, 0, 0);
        din_valid = 1'b1; step(); step();
        din_valid = 1'b0; rst = 1'b1; step();
        chk("t6rst_re", dout_real, 0);
        chk("t6rst_im", dout_imag, 0);
        chk("t6rst_ovf", ovf_sticky, 0);
        rst = 1'b0; step();
        nstb = 0;
        din_valid = 1'b1;
        for (int j = 0; j < 4; j++) count_step(nstb, "t6r", 8, 0);
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) count_step(nstb, "t6r", 8, 0);
        chk("t6r_count", nstb, 1);

        // exponent above MAXLOG clamps to 256-sample blocks
        acc_log2 = 4'd15; step(); step();
        set_din(1, 0, 0, 0, 3, 0, 0, 0);
        nstb = 0;
        din_valid = 1'b1;
        for (int j = 0; j < 256; j++) count_step(nstb, "t7", 1, 3);
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) count_step(nstb, "t7", 1, 3);
        chk("t7_count", nstb, 1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
